// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Sequential WIDTH-bit subtractor computing d = a - b - bin (mod 2^WIDTH).
// One 4-bit nibble is processed per clock, least-significant nibble first.
// Each nibble goes through a 4-bit carry-lookahead slice that adds a + ~b + c,
// where c is the inverse of the borrow registered from the previous nibble.
// The result is complete WIDTH/4 cycles after the operands are accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present on a, b, bin
//   in_ready   block can accept operands (high only in IDLE)
//   a          minuend (unsigned or two's complement)
//   b          subtrahend
//   bin        borrow in
//   out_valid  d, bout, ovf hold a finished result
//   out_ready  consumer accepts the result
//   d          (a - b - bin) mod 2^WIDTH
//   bout       unsigned borrow out: 1 iff a < b + bin
//   ovf        signed overflow of the subtraction
// -----------------------------------------------------------------------------
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    // A single-nibble instance still needs a one-bit counter to be legal.
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             bout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;

    logic [CW+1:0]    base;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       sum;
    logic             cout;
    logic             last;

    // 4-bit carry-lookahead adder slice: returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Datapath for the nibble selected by the counter. Subtraction is done
    // as a + ~b + ~borrow, so the slice carry-out is the inverted borrow.
    // NOTE: every signal written in always_comb gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        base  = {cnt_q, 2'b00};
        nib_a = a_q[base +: 4];
        nib_b = b_q[base +: 4];
        {cout, sum} = cla4(nib_a, ~nib_b, ~borrow_q);
        last  = (cnt_q == CW'(NIB - 1));
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last)     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: handshakes are pure functions of the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

    // Operand capture and per-nibble result accumulation. Clearing the result
    // registers on reset means an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    d_q[base +: 4] <= sum;
                    borrow_q       <= ~cout;
                    if (last) begin
                        // The counter only wraps on the way out of RUN.
                        cnt_q  <= '0;
                        bout_q <= ~cout;
                        // sum[3] is the MSB of the final result.
                        ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                                & (sum[3] ^ a_q[WIDTH-1]);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ; // DONE: hold the result stable
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16). The driver pushes
// the expected {d, bout, ovf} at every accepted operation; an independent
// monitor pops and compares whenever a result is transferred.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    // Reference model: plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] av,
                                   input logic [W-1:0] bv,
                                   input logic         bi);
        exp_t e;
        int   diff;
        diff   = int'(av) - int'(bv) - int'(bi);
        e.d    = diff[W-1:0];
        e.bout = (diff < 0);
        e.ovf  = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for acceptance, optionally score it.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, input bit push);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) sb_q.push_back(model(av, bv, bi));
        #1;
        in_valid = 1'b0;
        // Scramble the operand pins: only the accept edge may matter.
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    // Count edges from the current point until out_valid is seen.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            step();
            edges++;
        end
        if (!out_valid) check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Monitor: compare on every completed output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("d",    {16'd0, d},    {16'd0, e.d});
                check("bout", {31'd0, bout}, {31'd0, e.bout});
                check("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int edges;
        int guard;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_d",         {16'd0, d},         32'd0);
        check("rst_bout",      {31'd0, bout},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic operation with latency measurement.
        issue(16'h1234, 16'h0234, 1'b0, 1'b1);
        wait_valid(edges);
        check("latency", edges, NIB);

        // Directed boundary vectors.
        issue(16'h0000, 16'h0001, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        issue(16'h00F0, 16'h000F, 1'b1, 1'b1);
        issue(16'h0005, 16'h0005, 1'b1, 1'b1);
        issue(16'h8000, 16'h7FFF, 1'b1, 1'b1);
        issue(16'hFFFF, 16'h0000, 1'b0, 1'b1);

        // Backpressure: hold the result in DONE and poke the input side.
        wait_valid(edges);
        step();
        out_ready = 1'b0;
        issue(16'h1111, 16'h0222, 1'b0, 1'b1);
        wait_valid(edges);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            bin      = 1'($urandom);
            step();
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_d",         {16'd0, d},         32'h0EEF);
            check("bp_bout",      {31'd0, bout},      32'd0);
            check("bp_ovf",       {31'd0, ovf},       32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        issue(16'h5555, 16'h1111, 1'b0, 1'b1);

        // Reset while nibble 2 is being processed.
        wait_valid(edges);
        step();
        issue(16'hABCD, 16'h1234, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_d",         {16'd0, d},         32'd0);
        check("abort_bout",      {31'd0, bout},      32'd0);
        check("abort_ovf",       {31'd0, ovf},       32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_quiet", {31'd0, out_valid}, 32'd0);
        end
        issue(16'h1234, 16'h0234, 1'b0, 1'b1);

        // Random operands with random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        rand_ready = 1'b0;
        step();
        step();
        out_ready = 1'b1;

        // Drain the scoreboard.
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        check("drain", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Sequential N-bit subtractor: computes a - b - bin over WIDTH/4 cycles, one 4-bit nibble per cycle, LSB nibble first.
- Each nibble uses a 4-bit carry-lookahead slice: a + ~b + carry, where the slice carry-in is the inverted registered borrow.
- Inverse-operation companion to the team's structural 4-bit CLA adder; used in the datapath where area matters more than latency.
- Valid/ready handshakes on both input and output sides.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- d  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  unsigned borrow out; 1 iff a < b + bin
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and d[MSB] != a[MSB]

Behaviour:
- Reset: rst_n sampled low at a rising clk edge forces the following.
  - State goes to IDLE.
  - out_valid=0, d=0, bout=0, ovf=0.
  - Nibble counter and borrow register are cleared.
  - in_ready=1 from the first cycle after reset.
- Reset during RUN or DONE aborts the operation. No partial result becomes visible.
- FSM state IDLE: in_ready=1. On in_valid & in_ready:
  - capture a, b and bin into internal registers;
  - load the borrow register with bin;
  - clear the counter;
  - go to RUN.
- FSM state RUN: in_ready=0. Each cycle the block processes nibble k (the counter value):
  - s = a[4k+3:4k] + ~b[4k+3:4k] + ~borrow, using CLA generate/propagate terms;
  - store s into d[4k+3:4k];
  - borrow <= ~carry-out of the slice;
  - counter increments.
  - On the last nibble (k = NIB-1): latch bout from the final borrow, compute ovf, go to DONE.
- FSM state DONE: out_valid=1 and d, bout, ovf are held stable. in_ready=0, so in_valid is ignored.
  - On out_ready, go to IDLE; out_valid deasserts at the next edge.
- Latency: out_valid rises NIB edges after the accepting edge (4 edges for WIDTH=16).
- Throughput: one operation per NIB+2 cycles minimum. There is no same-cycle overlap of the output handshake with a new accept.
- Operand inputs are sampled only at the accept edge. Changes afterwards have no effect.
- d bits of nibbles not yet processed are unspecified until out_valid. The checker compares d only while out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH. Borrow propagates across nibble boundaries only through the registered borrow.
- The counter width is ceil(log2(NIB)) and wraps only via an FSM exit, never free-running.

Test Plan (WIDTH=16):
- 1234h - 0234h, bin=0 -> d=1000h, bout=0, ovf=0. out_valid high exactly 4 edges after accept.
- 0000h - 0001h, bin=0 -> d=FFFFh, bout=1, ovf=0. The borrow ripples through all 4 nibbles.
- 8000h - 0001h, bin=0 -> d=7FFFh, bout=0, ovf=1. Also 7FFFh - FFFFh -> d=8000h, bout=1, ovf=1.
- 00F0h - 000Fh, bin=1 -> d=00E0h, bout=0. Also 0005h - 0005h, bin=1 -> d=FFFFh, bout=1.
- Backpressure sequence:
  - hold out_ready=0 for 5 cycles in DONE -> d, bout, ovf stable and in_ready=0;
  - toggle in_valid with new operands meanwhile -> ignored;
  - assert out_ready -> IDLE with in_ready=1 next cycle;
  - next operation computes from freshly captured operands.
- Reset and random checks:
  - assert rst_n=0 during RUN at nibble 2 -> out_valid stays 0, all outputs 0, in_ready=1 after release;
  - a following operation 1234h - 0234h still gives 1000h;
  - then run 1000 random operands against a behavioural model.
